// File: rtl/axi4_lite_master_cmd_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_lite_master_cmd_if : AXI4-Lite channel bundle, master/slave views
// Revision: 1.0
// ---------------------------------------------------------------------------
interface axi4_lite_master_cmd_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_cmd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_lite_master_cmd : single-outstanding AXI4-Lite initiator for commands
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi4_lite_master_cmd #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic                            o_rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_rsp_timeout,
  axi4_lite_master_cmd_if.master          m_axi
);

  localparam int c_STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int c_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_WR_REQ  = 3'd1;
  localparam logic [2:0] c_S_WR_RESP = 3'd2;
  localparam logic [2:0] c_S_RD_REQ  = 3'd3;
  localparam logic [2:0] c_S_RD_DATA = 3'd4;
  localparam logic [2:0] c_S_RSP     = 3'd5;

  logic [2:0]                    r_state;
  logic [2:0]                    w_state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [c_STRB_W-1:0]           r_wstrb;
  logic                          r_write;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic [c_CNT_W-1:0]            r_cnt;
  logic [c_CNT_W-1:0]            w_cnt_next;
  logic                          r_rsp_write;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                    r_rsp_resp;
  logic                          r_rsp_timeout;

  logic w_cmd_ready, w_rsp_valid;
  logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic w_cmd_acc, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_busy;

  assign w_cmd_acc = i_cmd_valid && w_cmd_ready;
  assign w_aw_hs   = w_awvalid && m_axi.awready;
  assign w_w_hs    = w_wvalid  && m_axi.wready;
  assign w_b_hs    = w_bready  && m_axi.bvalid;
  assign w_ar_hs   = w_arvalid && m_axi.arready;
  assign w_r_hs    = w_rready  && m_axi.rvalid;
  assign w_busy    = (r_state == c_S_WR_REQ) || (r_state == c_S_WR_RESP) ||
                     (r_state == c_S_RD_REQ) || (r_state == c_S_RD_DATA);
  assign w_cnt_next = (r_cnt == c_TMO) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE:    if (w_cmd_acc) w_state_next = i_cmd_write ? c_S_WR_REQ : c_S_RD_REQ;
      // AW and W may complete in either order or together
      c_S_WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = c_S_WR_RESP;
      c_S_WR_RESP: if (w_b_hs) w_state_next = c_S_RSP;
      c_S_RD_REQ:  if (w_ar_hs) w_state_next = c_S_RD_DATA;
      c_S_RD_DATA: if (w_r_hs) w_state_next = c_S_RSP;
      c_S_RSP:     if (i_rsp_ready) w_state_next = c_S_IDLE;
      default:     w_state_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      c_S_IDLE:    w_cmd_ready = 1'b1;
      c_S_WR_REQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      c_S_WR_RESP: w_bready    = 1'b1;
      c_S_RD_REQ:  w_arvalid   = 1'b1;
      c_S_RD_DATA: w_rready    = 1'b1;
      c_S_RSP:     w_rsp_valid = 1'b1;
      default:     w_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_write       <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_cnt         <= '0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_cmd_acc) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_write   <= i_cmd_write;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_cnt     <= '0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
        if (w_busy)  r_cnt     <= w_cnt_next;
      end
      // Timeout uses the count as it stands after the completing edge
      if (w_b_hs) begin
        r_rsp_write   <= r_write;
        r_rsp_rdata   <= '0;
        r_rsp_resp    <= m_axi.bresp;
        r_rsp_timeout <= (w_cnt_next == c_TMO);
      end
      if (w_r_hs) begin
        r_rsp_write   <= r_write;
        r_rsp_rdata   <= m_axi.rdata;
        r_rsp_resp    <= m_axi.rresp;
        r_rsp_timeout <= (w_cnt_next == c_TMO);
      end
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_rsp_valid   = w_rsp_valid;
  assign o_rsp_write   = r_rsp_write;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_timeout = r_rsp_timeout;

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = w_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.bready  = w_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = w_arvalid;
  assign m_axi.rready  = w_rready;

endmodule
`default_nettype wire

// File: doc/axi4_lite_master_cmd.md
# axi4_lite_master_cmd

AXI4-Lite initiator that turns single register-access commands into AXI4-Lite write or read transactions and returns the slave's response. It drives the AXI4-Lite slave register blocks (parameter/GPIO register banks) from on-chip control logic, for example boot-time parameter loaders or self-test sequencers, so no external processor is needed. It handles one outstanding transaction at a time, issues AW and W together, and reports a timeout flag.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width. Only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 4, byte-address width.
- TIMEOUT_CYCLES, 1024, latency threshold in clk cycles for rsp_timeout. Must be ≥1. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data. Ignored for reads.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes. Ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data. 0 for writes.
- rsp_resp  out  2  BRESP or RRESP from the slave.
- rsp_timeout  out  1  1 if the completing handshake came TIMEOUT_CYCLES or more cycles after command acceptance.
- M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID/AWREADY, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID/WREADY, M_AXI_BRESP, M_AXI_BVALID/BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID/ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID/RREADY:
  - standard AXI4-Lite master side, widths per the parameters;
  - AWPROT and ARPROT are tied to 3'b000.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On acceptance, register addr, wdata, wstrb and the write flag.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - Each deasserts independently on its own handshake; per-channel done flags track this.
  - Go to WR_RESP once both are done. This includes the case where both handshake in the same cycle.
- WR_RESP:
  - BREADY=1.
  - On the B handshake, capture BRESP, set rsp_rdata=0 and go to RSP.
- RD_REQ: ARVALID=1 until the AR handshake, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On the R handshake, capture RDATA and RRESP and go to RSP.
- RSP:
  - rsp_valid=1, with all rsp_* fields held stable.
  - On the rsp handshake, go to IDLE.
- The slave's response code is passed through unmodified. SLVERR/DECERR are not retried.
- Timeout counter:
  - cleared on command acceptance;
  - increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA;
  - saturates at TIMEOUT_CYCLES.
  - rsp_timeout = (counter == TIMEOUT_CYCLES), latched at the B/R handshake.
  - The transaction is never aborted. A timeout is only flagged.
- Address and data are registered. The AXI outputs are driven from registers, not combinationally from cmd_*.

## Timing
- Reset values:
  - state = IDLE, cmd_ready = 1;
  - all AXI VALID/READY outputs = 0;
  - rsp_valid = 0, rsp_* = 0;
  - AXI addr/data/strb outputs = 0;
  - counter = 0.
- Reset mid-transaction drops all VALID/READY outputs on the next edge and returns to IDLE. The system must reset the slave at the same time.
- Write with a zero-wait slave (AWREADY=WREADY=1, BVALID one cycle after the W handshake):
  - command accepted at edge 0;
  - AW/W valid in cycle 1, handshake at edge 1;
  - BVALID and BREADY in cycle 2;
  - rsp_valid in cycle 3.
- Read with a zero-wait slave (RVALID one cycle after AR): rsp_valid in cycle 3.
- Once asserted, VALID stays high until its handshake. AWADDR/WDATA/ARADDR are stable while VALID is high.
- BREADY/RREADY are asserted only in WR_RESP/RD_DATA. They never precede the request channel.
- cmd_ready=0 from the cycle after acceptance through the rsp handshake cycle. It returns to 1 the cycle after.
- Back-to-back commands are accepted at most once per 4 cycles with a zero-wait slave.
- With rsp_ready held at 1, RSP lasts exactly one cycle.

## Test plan
- Write, zero-wait slave: cmd addr=0x4, wdata=0xDEADBEEF, wstrb=0xF → AWADDR=0x4 and WDATA=0xDEADBEEF in cycle 1; rsp_valid in cycle 3 with rsp_resp=0, rsp_write=1, rsp_rdata=0, rsp_timeout=0.
- Skewed write: WREADY 3 cycles before AWREADY → WVALID drops after its handshake, AWVALID holds until its handshake; BREADY rises only after both handshakes; one response is returned.
- Read with backpressure:
  - stimulus: addr=0x8, ARREADY delayed 2 cycles, RDATA=0x0000C350, RRESP=2, rsp_ready held low for 5 cycles;
  - response: rsp_rdata=0x0000C350 and rsp_resp=2 held stable; cmd_ready=0 until the rsp handshake.
- Timeout: TIMEOUT_CYCLES=8, BVALID withheld 20 cycles → transaction completes with rsp_timeout=1. With BVALID after 3 cycles, rsp_timeout=0.
- Reset mid-read: rst in the RD_DATA state → next cycle RREADY=0, ARVALID=0, cmd_ready=1, rsp_valid=0. A subsequent write completes normally.
- Back-to-back: 4 alternating write/read commands with cmd_valid held high → each is accepted only in IDLE, responses come in order, and there are no overlapping AXI transactions.
